// File: rtl/endp_pkg.sv
// rtl/endp_pkg.sv - opcodes and sweep FSM encoding for the endpoint register bank
package endp_pkg;
   localparam logic [2:0] OP_NOP    = 3'b000;
   localparam logic [2:0] OP_SETL   = 3'b001;
   localparam logic [2:0] OP_SETR   = 3'b010;
   localparam logic [2:0] OP_XORL   = 3'b011;
   localparam logic [2:0] OP_XORR   = 3'b100;
   localparam logic [2:0] OP_SWAP   = 3'b101;
   localparam logic [2:0] OP_CLR    = 3'b110;
   localparam logic [2:0] OP_CLRALL = 3'b111;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } sweep_state_t;
endpackage

// File: rtl/endp_pair.sv
// rtl/endp_pair.sv - one L/R endpoint register pair
module endp_pair #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       op,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q_l,
   output logic [WIDTH-1:0] q_r
);
   import endp_pkg::*;

   // Sweep clear wins; it can only coincide with en if the top misdecodes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_l <= '0;
         q_r <= '0;
      end else if (clr) begin
         q_l <= '0;
         q_r <= '0;
      end else if (en) begin
         case (op)
            OP_SETL: q_l <= d;
            OP_SETR: q_r <= d;
            OP_XORL: q_l <= q_l ^ d;
            OP_XORR: q_r <= q_r ^ d;
            OP_SWAP: begin
               q_l <= q_r;
               q_r <= q_l;
            end
            OP_CLR: begin
               q_l <= '0;
               q_r <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/endp_reg_bank.sv
// rtl/endp_reg_bank.sv - multi-channel L/R endpoint registers with XOR read-out and clear-all sweep
module endp_reg_bank #(
   parameter int WIDTH    = 1,
   parameter int CHANNELS = 4,
   parameter int CH_W     = ($clog2(CHANNELS) > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       inst,
   input  logic [CH_W-1:0]  wr_ch,
   input  logic [WIDTH-1:0] ztonxor,
   input  logic [CH_W-1:0]  rd_ch,
   output logic [WIDTH-1:0] ltorxor,
   output logic             busy,
   output logic             err
);
   import endp_pkg::*;

   localparam logic [CH_W:0]   CH_LIMIT = (CH_W+1)'(CHANNELS);
   localparam logic [CH_W-1:0] LAST_CH  = CH_W'(CHANNELS - 1);

   sweep_state_t    state, state_nx;
   logic [CH_W-1:0] cnt, cnt_nx;
   logic            accept, wr_op, wr_oob, start_clr;
   logic [WIDTH-1:0] q_l [CHANNELS];
   logic [WIDTH-1:0] q_r [CHANNELS];

   assign busy      = (state == ST_SWEEP);
   assign accept    = ~busy;
   assign wr_op     = (inst != OP_NOP) && (inst != OP_CLRALL);
   assign wr_oob    = ({1'b0, wr_ch} >= CH_LIMIT);
   assign start_clr = accept && (inst == OP_CLRALL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Counter parks on the last channel when the sweep ends; it is reloaded on start.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         ST_IDLE: begin
            if (start_clr) begin
               state_nx = ST_SWEEP;
               cnt_nx   = '0;
            end
         end
         ST_SWEEP: begin
            if (cnt == LAST_CH) state_nx = ST_IDLE;
            else                cnt_nx   = cnt + CH_W'(1);
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                           err <= 1'b0;
      else if (accept && wr_op && wr_oob)  err <= 1'b1;
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_pair
      endp_pair #(.WIDTH(WIDTH)) u_pair (
         .clk   (clk),
         .reset (reset),
         .op    (inst),
         .en    (accept && wr_op && (wr_ch == CH_W'(i))),
         .clr   (busy && (cnt == CH_W'(i))),
         .d     (ztonxor),
         .q_l   (q_l[i]),
         .q_r   (q_r[i])
      );
   end

   always_comb begin
      ltorxor = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (rd_ch == CH_W'(i)) ltorxor = q_l[i] ^ q_r[i];
      end
   end
endmodule
